lif_spike_ctrl: RTL

//  Control stage wrapped around the LIF accumulator. Drives its add_en/sub_en/load_reset/add/sub

---
 rtl/lif_spike_ctrl_if.sv | 25 ++
 rtl/lif_spike_ctrl.sv | 106 ++++++++++
 2 files changed

// File: rtl/lif_spike_ctrl_if.sv
// Event-input and accumulator-side bundle for lif_spike_ctrl.
// The slave modport is the controller's view; the master modport is the environment's view.
interface lif_spike_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_weight;
  logic             in_ready;
  logic             thresh_hit;
  logic             add_en;
  logic [WIDTH-1:0] add;
  logic             sub_en;
  logic [WIDTH-1:0] sub;
  logic             load_reset;

  modport master (
    output in_valid, in_weight, thresh_hit,
    input  in_ready, add_en, add, sub_en, sub, load_reset
  );

  modport slave (
    input  in_valid, in_weight, thresh_hit,
    output in_ready, add_en, add, sub_en, sub, load_reset
  );
endinterface

// File: rtl/lif_spike_ctrl.sv
// LIF spike controller: integrates weighted events with a periodic leak, fires and goes refractory.
// LIF_SPIKE_COUNT_EN enables the saturating spike counter; otherwise spike_count is tied to 0.
module lif_spike_ctrl #(
  parameter int WIDTH         = 8,
  parameter int LEAK_PERIOD   = 4,
  parameter int LEAK_AMT      = 1,
  parameter int REFRAC_CYCLES = 3,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  lif_spike_ctrl_if.slave  bus,
  output logic             spike,
  output logic             refrac,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] spike_count
);
  localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
  localparam int RCW = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
  localparam logic [LCW-1:0] LEAK_LAST = LCW'(LEAK_PERIOD - 1);
  localparam logic [RCW-1:0] REF_INIT  = RCW'((REFRAC_CYCLES > 0) ? REFRAC_CYCLES - 1 : 0);

  typedef enum logic [1:0] {INTEG, FIRE, REFRAC} state_t;

  state_t         state, state_d;
  logic [LCW-1:0] leak_cnt, leak_cnt_d;
  logic [RCW-1:0] ref_cnt, ref_cnt_d;
  logic           leak_pend, leak_pend_d;
  logic           leak_tick;

  assign leak_tick = (leak_cnt == LEAK_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INTEG;
      leak_cnt  <= '0;
      leak_pend <= 1'b0;
      ref_cnt   <= '0;
    end else begin
      state     <= state_d;
      leak_cnt  <= leak_cnt_d;
      leak_pend <= leak_pend_d;
      ref_cnt   <= ref_cnt_d;
    end
  end

  always_comb begin
    state_d        = state;
    leak_cnt_d     = leak_cnt;
    leak_pend_d    = leak_pend;
    ref_cnt_d      = ref_cnt;
    bus.in_ready   = 1'b0;
    bus.add_en     = 1'b0;
    bus.add        = '0;
    bus.sub_en     = 1'b0;
    bus.sub        = '0;
    bus.load_reset = 1'b0;
    spike          = 1'b0;
    refrac         = 1'b0;
    case (state)
      INTEG: begin
        bus.in_ready = ~bus.thresh_hit;
        leak_cnt_d   = leak_tick ? '0 : leak_cnt + 1'b1;
        // One accumulator op per cycle; a leak that loses arbitration is remembered once.
        if (bus.thresh_hit) begin
          state_d = FIRE;
          if (leak_tick) leak_pend_d = 1'b1;
        end else if (bus.in_valid) begin
          bus.add_en = 1'b1;
          bus.add    = bus.in_weight;
          if (leak_tick) leak_pend_d = 1'b1;
        end else if (leak_pend || leak_tick) begin
          bus.sub_en  = 1'b1;
          bus.sub     = WIDTH'(LEAK_AMT);
          leak_pend_d = 1'b0;
        end
      end
      FIRE: begin
        spike          = 1'b1;
        bus.load_reset = 1'b1;
        leak_cnt_d     = '0;
        leak_pend_d    = 1'b0;
        ref_cnt_d      = REF_INIT;
        state_d        = (REFRAC_CYCLES > 0) ? REFRAC : INTEG;
      end
      REFRAC: begin
        refrac = 1'b1;
        if (ref_cnt == '0) state_d = INTEG;
        else               ref_cnt_d = ref_cnt - 1'b1;
      end
      default: state_d = INTEG;
    endcase
  end

`ifdef LIF_SPIKE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    spike_count <= '0;
    else if (cnt_clr)                              spike_count <= '0;
    else if (state == FIRE && spike_count != '1)   spike_count <= spike_count + 1'b1;
  end
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign spike_count    = '0;
`endif
endmodule
